vram_arbiter: RTL and testbench
===============================

Name: vram_arbiter

Overview:
- Shares the single-port synchronous pixel SRAM between two requesters: the display scan-out fetch and the command processor's pixel writes.
- Display reads have absolute priority, because scan-out has a hard deadline of one fetch per 40 MHz pixel tick.
- Command writes are buffered in a small FIFO and drained into free memory cycles.
- Sits between the command-processing logic, the pixel generator and the external SRAM pins. All logic runs in the 120 MHz PLL clock domain.

Parameters:
- ADDR_W, 16, memory address width.
- DATA_W, 8, memory data width.
- WBUF_DEPTH, 4, write-buffer entries; power of two, minimum 2.
- RD_LAT, 2, clocks from mem_en (read) to valid mem_rdata; range 1..3.

Ports:
- clk  in  1  system clock (120 MHz PLL output, global buffer).
- rst  in  1  asynchronous active-high reset.
- disp_req  in  1  display fetch request; single-cycle pulse, at most one per 3 clocks.
- disp_addr  in  ADDR_W  fetch address, valid with disp_req.
- disp_data  out  DATA_W  fetched pixel data.
- disp_valid  out  1  disp_data valid; one-cycle pulse.
- wr_valid  in  1  command write request.
- wr_addr  in  ADDR_W  write address.
- wr_data  in  DATA_W  write data.
- wr_ready  out  1  write buffer can accept an entry.
- wbuf_empty  out  1  no pending writes.
- mem_en  out  1  memory cycle enable.
- mem_we  out  1  memory write enable; qualified by mem_en.
- mem_addr  out  ADDR_W  memory address.
- mem_wdata  out  DATA_W  memory write data.
- mem_rdata  in  DATA_W  memory read data.

Behaviour:
- Reset (rst high, asynchronous) forces the following, all with pending writes discarded and in-flight reads cancelled:
  - mem_en=0, mem_we=0, mem_addr=0, mem_wdata=0.
  - disp_valid=0, disp_data=0.
  - wr_ready=1, wbuf_empty=1.
  - Write FIFO pointers and count = 0; read-latency pipeline cleared.
- Write acceptance: an entry is pushed on a clock edge where wr_valid && wr_ready.
  - wr_ready = (count < WBUF_DEPTH), registered, reflecting the count after this edge.
  - A push while full is ignored and must not corrupt entries.
- Per-clock slot decision, registered outputs, one memory cycle per clock:
  - disp_req=1: issue read (mem_en=1, mem_we=0, mem_addr=disp_addr) next cycle. Always wins, even if the FIFO is full.
  - Else, FIFO non-empty: pop the head and issue a write (mem_en=1, mem_we=1, head addr/data) next cycle.
  - Else: mem_en=0, mem_we=0; mem_addr/mem_wdata hold their last values.
- Simultaneous push and pop in one edge: count unchanged. A push into an empty FIFO is not eligible for a pop on the same edge; earliest write issue is the next decision.
- Read return: disp_valid pulses exactly 1+RD_LAT clocks after the disp_req edge. disp_data = mem_rdata sampled at that point. Implement with a RD_LAT-deep valid shift register.
- Ordering and hazards:
  - Writes retire in FIFO order.
  - No read forwarding: a read to an address with a pending buffered write returns the old memory contents.
  - A read issued after the write's mem cycle returns the new data.
- Starvation: with disp_req at its maximum rate (1 in 3), at least 2 of every 3 cycles are write slots. The FIFO drains whenever writes stop.
- wbuf_empty = (count==0), registered.
- Reset asserted mid-read suppresses the pending disp_valid. Reset asserted mid-write leaves the SRAM cycle truncated; software must not rely on that write.
- disp_req more often than 1 per 3 clocks: every request is still served in order; write slots may starve. This is out of contract but must not deadlock.

Test Plan:
- Reset then idle: mem_en=0, wr_ready=1, wbuf_empty=1, disp_valid=0 for 20 clocks.
- Single read, RD_LAT=2: disp_req with addr 0x0123 at edge N → mem_en=1, mem_we=0, mem_addr=0x0123 in cycle N+1; model returns 0x5A; disp_valid=1 with disp_data=0x5A at edge N+3 only.
- Fill buffer with disp_req held on every cycle: push 4 writes (0x0010..0x0013, data 0xA0..0xA3) → wr_ready=0 after the 4th; 5th push ignored. Release disp_req → four writes issue in order on consecutive cycles; wbuf_empty=1 after the last.
- Interleave: disp_req every 3rd clock while pushing one write per clock → every read issues the cycle after its request; writes occupy only the other slots in order; no entry lost or duplicated.
- Hazard: push write 0x0040/0x77 then disp_req 0x0040 on the next edge → read returns the old value 0x00. A second read after wbuf_empty returns 0x77.
- Async reset with 3 writes pending and a read in flight → outputs go to reset values immediately without a clock edge; no disp_valid afterwards; wbuf_empty=1.

Source files
------------

// File: rtl/vram_arbiter.sv
// Arbitrates the single-port pixel SRAM between display scan-out reads and
// buffered command-processor writes. Display reads always win the slot.
module vram_arbiter #(
    parameter int ADDR_W     = 16,
    parameter int DATA_W     = 8,
    parameter int WBUF_DEPTH = 4,
    parameter int RD_LAT     = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              disp_req,
    input  logic [ADDR_W-1:0] disp_addr,
    output logic [DATA_W-1:0] disp_data,
    output logic              disp_valid,
    input  logic              wr_valid,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [DATA_W-1:0] wr_data,
    output logic              wr_ready,
    output logic              wbuf_empty,
    output logic              mem_en,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata
);

    localparam int PTR_W = (WBUF_DEPTH > 1) ? $clog2(WBUF_DEPTH) : 1;
    localparam int CNT_W = PTR_W + 1;

    logic [ADDR_W-1:0] buf_addr_q [WBUF_DEPTH];
    logic [ADDR_W-1:0] buf_addr_d [WBUF_DEPTH];
    logic [DATA_W-1:0] buf_data_q [WBUF_DEPTH];
    logic [DATA_W-1:0] buf_data_d [WBUF_DEPTH];

    logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]  count_q, count_d;
    logic              wr_ready_q, wr_ready_d;
    logic              wbuf_empty_q, wbuf_empty_d;

    logic              mem_en_q, mem_en_d;
    logic              mem_we_q, mem_we_d;
    logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
    logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;

    logic [RD_LAT-1:0] rd_pipe_q, rd_pipe_d;
    logic              disp_valid_q, disp_valid_d;
    logic [DATA_W-1:0] disp_data_q, disp_data_d;

    logic              push;
    logic              pop;

    always_comb begin
        push = wr_valid && wr_ready_q;
        // Pop uses the registered count, so an entry pushed this edge waits a slot.
        pop  = !disp_req && (count_q != '0);

        buf_addr_d = buf_addr_q;
        buf_data_d = buf_data_q;
        if (push) begin
            buf_addr_d[wr_ptr_q] = wr_addr;
            buf_data_d[wr_ptr_q] = wr_data;
        end

        wr_ptr_d = push ? wr_ptr_q + PTR_W'(1) : wr_ptr_q;
        rd_ptr_d = pop  ? rd_ptr_q + PTR_W'(1) : rd_ptr_q;

        case ({push, pop})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase
        wr_ready_d   = count_d < CNT_W'(WBUF_DEPTH);
        wbuf_empty_d = count_d == '0;

        mem_en_d    = 1'b0;
        mem_we_d    = 1'b0;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        if (disp_req) begin
            mem_en_d   = 1'b1;
            mem_addr_d = disp_addr;
        end else if (pop) begin
            mem_en_d    = 1'b1;
            mem_we_d    = 1'b1;
            mem_addr_d  = buf_addr_q[rd_ptr_q];
            mem_wdata_d = buf_data_q[rd_ptr_q];
        end

        // One bit per clock of SRAM read latency, seeded by the issued read cycle.
        rd_pipe_d    = (rd_pipe_q << 1) | RD_LAT'(mem_en_q && !mem_we_q);
        disp_valid_d = rd_pipe_q[RD_LAT-1];
        disp_data_d  = disp_valid_d ? mem_rdata : disp_data_q;
    end

    always_ff @(posedge clk) begin
        buf_addr_q <= buf_addr_d;
        buf_data_q <= buf_data_d;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            count_q      <= '0;
            wr_ready_q   <= 1'b1;
            wbuf_empty_q <= 1'b1;
            mem_en_q     <= 1'b0;
            mem_we_q     <= 1'b0;
            mem_addr_q   <= '0;
            mem_wdata_q  <= '0;
            rd_pipe_q    <= '0;
            disp_valid_q <= 1'b0;
            disp_data_q  <= '0;
        end else begin
            wr_ptr_q     <= wr_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
            count_q      <= count_d;
            wr_ready_q   <= wr_ready_d;
            wbuf_empty_q <= wbuf_empty_d;
            mem_en_q     <= mem_en_d;
            mem_we_q     <= mem_we_d;
            mem_addr_q   <= mem_addr_d;
            mem_wdata_q  <= mem_wdata_d;
            rd_pipe_q    <= rd_pipe_d;
            disp_valid_q <= disp_valid_d;
            disp_data_q  <= disp_data_d;
        end
    end

    assign wr_ready   = wr_ready_q;
    assign wbuf_empty = wbuf_empty_q;
    assign mem_en     = mem_en_q;
    assign mem_we     = mem_we_q;
    assign mem_addr   = mem_addr_q;
    assign mem_wdata  = mem_wdata_q;
    assign disp_valid = disp_valid_q;
    assign disp_data  = disp_data_q;

endmodule

// File: tb/tb_vram_arbiter.sv
// Scoreboard bench for vram_arbiter: stimulus queues expected writes and read
// data; a negedge monitor checks every memory cycle and every disp_valid pulse.
module tb_vram_arbiter;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        disp_req = 1'b0;
    logic [15:0] disp_addr = '0;
    logic [7:0]  disp_data;
    logic        disp_valid;
    logic        wr_valid = 1'b0;
    logic [15:0] wr_addr = '0;
    logic [7:0]  wr_data = '0;
    logic        wr_ready;
    logic        wbuf_empty;
    logic        mem_en;
    logic        mem_we;
    logic [15:0] mem_addr;
    logic [7:0]  mem_wdata;
    logic [7:0]  mem_rdata;

    int total = 0;
    int bad   = 0;

    logic [23:0] wq[$];
    logic [7:0]  rdq[$];

    logic [7:0]  sram [0:65535];
    logic [7:0]  rd_s1, rd_s2;

    logic [3:0]  req_pipe;
    logic [15:0] req_addr1;

    vram_arbiter dut (
        .clk(clk), .rst(rst),
        .disp_req(disp_req), .disp_addr(disp_addr),
        .disp_data(disp_data), .disp_valid(disp_valid),
        .wr_valid(wr_valid), .wr_addr(wr_addr), .wr_data(wr_data),
        .wr_ready(wr_ready), .wbuf_empty(wbuf_empty),
        .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
    );

    always #5 clk = ~clk;

    // SRAM model: two-stage read pipeline, write on the enabled cycle.
    always @(posedge clk) begin
        if (mem_en && mem_we) sram[mem_addr] <= mem_wdata;
        rd_s1 <= (mem_en && !mem_we) ? sram[mem_addr] : 8'h00;
        rd_s2 <= rd_s1;
    end
    assign mem_rdata = rd_s2;

    // Expected read timing: issue one cycle after request, valid three after.
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            req_pipe  <= '0;
            req_addr1 <= '0;
        end else begin
            req_pipe  <= {req_pipe[2:0], disp_req};
            req_addr1 <= disp_addr;
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    always @(negedge clk) begin
        logic [23:0] w;
        logic [7:0]  d;
        if (!rst) begin
            chk("disp_valid_timing", {31'd0, disp_valid}, {31'd0, req_pipe[3]});
            if (req_pipe[0])
                chk("read_issue", {15'd0, mem_en, mem_we, mem_addr}, {15'd0, 1'b1, 1'b0, req_addr1});
            if (mem_en && mem_we) begin
                if (wq.size() == 0) begin
                    chk("unexpected_write", {8'd0, mem_addr, mem_wdata}, 32'hFFFF_FFFF);
                end else begin
                    w = wq.pop_front();
                    chk("write_op", {8'd0, mem_addr, mem_wdata}, {8'd0, w});
                end
            end
            if (disp_valid) begin
                if (rdq.size() == 0) begin
                    chk("unexpected_read_data", {24'd0, disp_data}, 32'hFFFF_FFFF);
                end else begin
                    d = rdq.pop_front();
                    chk("read_data", {24'd0, disp_data}, {24'd0, d});
                end
            end
        end
    end

    initial begin
        for (int i = 0; i < 65536; i++) sram[i] = 8'h00;
        sram[16'h0123] = 8'h5A;
        sram[16'h0200] = 8'h11;
        rd_s1 = 8'h00;
        rd_s2 = 8'h00;

        repeat (3) cyc();
        rst = 1'b0;

        // Reset then idle
        for (int i = 0; i < 20; i++) begin
            cyc();
            chk("idle_out", {28'd0, mem_en, wr_ready, wbuf_empty, disp_valid}, 32'h6);
        end

        // Single read of 0x0123
        disp_req = 1'b1; disp_addr = 16'h0123; rdq.push_back(8'h5A);
        cyc();
        disp_req = 1'b0; disp_addr = 16'h0000;
        chk("single_rd_issue", {15'd0, mem_en, mem_we, mem_addr}, {15'd0, 2'b10, 16'h0123});
        cyc();
        cyc();
        chk("single_rd_early", {31'd0, disp_valid}, 32'd0);
        cyc();
        chk("single_rd_valid", {23'd0, disp_valid, disp_data}, {23'd0, 1'b1, 8'h5A});
        cyc();
        chk("single_rd_pulse", {31'd0, disp_valid}, 32'd0);
        repeat (3) cyc();

        // Fill the buffer while reads hog every slot
        for (int i = 0; i < 5; i++) begin
            disp_req = 1'b1; disp_addr = 16'h0200; rdq.push_back(8'h11);
            wr_valid = 1'b1; wr_addr = 16'h0010 + 16'(i); wr_data = 8'hA0 + 8'(i);
            if (i < 4) wq.push_back({wr_addr, wr_data});
            cyc();
            if (i == 0) chk("fill_ready_1", {30'd0, wr_ready, wbuf_empty}, 32'h2);
            if (i == 3) chk("fill_full", {30'd0, wr_ready, wbuf_empty}, 32'h0);
        end
        wr_valid = 1'b0;
        rdq.push_back(8'h11);
        cyc();
        chk("fill_still_full", {30'd0, wr_ready, mem_we}, 32'h0);
        disp_req = 1'b0;
        for (int k = 0; k < 4; k++) begin
            cyc();
            chk("drain_slot", {30'd0, mem_en, mem_we}, 32'h3);
        end
        chk("drain_empty", {30'd0, wr_ready, wbuf_empty}, 32'h3);
        cyc();
        chk("drain_idle", {31'd0, mem_en}, 32'd0);
        repeat (4) cyc();

        // Interleave: read every third clock, one write push per clock
        for (int i = 0; i < 14; i++) begin
            disp_req = (i % 3 == 0);
            disp_addr = 16'h0123;
            if (disp_req) rdq.push_back(8'h5A);
            if (i < 9) begin
                wr_valid = 1'b1; wr_addr = 16'h0300 + 16'(i); wr_data = 8'hB0 + 8'(i);
                wq.push_back({wr_addr, wr_data});
            end else begin
                wr_valid = 1'b0;
            end
            cyc();
            if (i < 9) chk("ilv_ready", {31'd0, wr_ready}, 32'd1);
        end
        disp_req = 1'b0; wr_valid = 1'b0;
        chk("ilv_empty", {31'd0, wbuf_empty}, 32'd1);
        repeat (5) cyc();

        // Hazard: buffered write is not forwarded to a following read
        wr_valid = 1'b1; wr_addr = 16'h0040; wr_data = 8'h77;
        wq.push_back({wr_addr, wr_data});
        cyc();
        wr_valid = 1'b0;
        disp_req = 1'b1; disp_addr = 16'h0040; rdq.push_back(8'h00);
        cyc();
        disp_req = 1'b0;
        repeat (5) cyc();
        chk("hazard_empty", {31'd0, wbuf_empty}, 32'd1);
        disp_req = 1'b1; disp_addr = 16'h0040; rdq.push_back(8'h77);
        cyc();
        disp_req = 1'b0;
        repeat (5) cyc();
        chk("queues_drained", {wq.size() == 0, rdq.size() == 0}, 32'h3);

        // Async reset with writes pending and a read in flight
        for (int i = 0; i < 3; i++) begin
            disp_req = 1'b1; disp_addr = 16'h0200;
            wr_valid = 1'b1; wr_addr = 16'h0500 + 16'(i); wr_data = 8'hC0 + 8'(i);
            cyc();
        end
        disp_req = 1'b0; wr_valid = 1'b0;
        #1;
        rst = 1'b1;
        wq.delete();
        rdq.delete();
        #1;
        chk("rst_mem_ctl", {30'd0, mem_en, mem_we}, 32'd0);
        chk("rst_mem_addr", {16'd0, mem_addr}, 32'd0);
        chk("rst_mem_wdata", {24'd0, mem_wdata}, 32'd0);
        chk("rst_disp", {23'd0, disp_valid, disp_data}, 32'd0);
        chk("rst_flags", {30'd0, wr_ready, wbuf_empty}, 32'h3);
        repeat (2) cyc();
        rst = 1'b0;
        for (int i = 0; i < 8; i++) begin
            cyc();
            chk("post_rst", {29'd0, mem_en, disp_valid, wbuf_empty}, 32'h1);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
